// File: rtl/motor_link_host.sv
// motor_link_host: host-side initiator for the motor controller serial link.
// Frames 5-byte motion commands and 1-byte status polls onto a byte
// transmitter, then collects and validates the 4-byte status reply.
module motor_link_host #(
   parameter int unsigned GAP_CYCLES   = 4095,
   parameter int unsigned RESP_TIMEOUT = 262143
) (
   input  logic        CLOCK_25,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_motor,
   input  logic [15:0] cmd_divider,
   input  logic [10:0] cmd_steps,
   input  logic        cmd_dir,
   output logic        cmd_reject,
   input  logic        poll_req,
   output logic        status_valid,
   output logic        status_timeout,
   output logic [9:0]  pending,
   output logic [9:0]  term_active,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready
);

   // One counter serves both the inter-byte gap and the reply timeout.
   localparam int unsigned     CW           = $clog2(RESP_TIMEOUT + 1);
   localparam logic [CW-1:0]   GAP_LOAD     = CW'(GAP_CYCLES);
   localparam logic [CW-1:0]   TIMEOUT_LOAD = CW'(RESP_TIMEOUT);
   localparam logic [7:0]      POLL_BYTE    = 8'h0F;

   typedef enum logic [2:0] {
      IDLE,
      TX_BYTE,
      TX_WAIT,
      TX_GAP,
      RX_WAIT
   } stateType;

   stateType        state;
   stateType        stateNext;
   logic [CW-1:0]   cnt;
   logic [31:0]     frameRest;
   logic [2:0]      bytesLeft;
   logic            isPoll;
   logic            skipBusy;
   logic            rxPrev;
   logic            rxRise;
   logic            replyMatch;
   logic            resyncByte;
   logic [1:0]      rxIdx;
   logic [14:0]     shadow;

   // Next-state and combinational outputs; tx_start is a Moore-style launch
   // from TX_BYTE so the byte leaves exactly GAP_CYCLES+1 cycles after busy drops.
   always_comb begin
      stateNext  = state;
      cmd_ready  = 1'b0;
      tx_start   = 1'b0;
      rxRise     = rx_ready && !rxPrev;
      replyMatch = rxRise && (rx_data[7:6] == rxIdx) && !rx_data[5];
      resyncByte = rxRise && !replyMatch && (rx_data[7:6] == 2'd0) && !rx_data[5];
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_motor <= 4'd9) begin
                  stateNext = TX_BYTE;
               end
            end else if (poll_req) begin
               stateNext = TX_BYTE;
            end
         end
         TX_BYTE: begin
            if (!tx_busy) begin
               tx_start  = reset_n;
               stateNext = TX_WAIT;
            end
         end
         TX_WAIT: begin
            if (!skipBusy && !tx_busy) begin
               stateNext = TX_GAP;
            end
         end
         TX_GAP: begin
            if (cnt == '0) begin
               if (bytesLeft != 3'd0) begin
                  stateNext = TX_BYTE;
               end else if (isPoll) begin
                  stateNext = RX_WAIT;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         RX_WAIT: begin
            if (replyMatch) begin
               if (rxIdx == 2'd3) begin
                  stateNext = IDLE;
               end
            end else if (cnt == '0) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge CLOCK_25) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Frame loading, gap/timeout counting, reply assembly and status pulses.
   always_ff @(posedge CLOCK_25) begin
      if (!reset_n) begin
         cmd_reject     <= 1'b0;
         status_valid   <= 1'b0;
         status_timeout <= 1'b0;
         tx_data        <= '0;
         pending        <= '0;
         term_active    <= '0;
         cnt            <= '0;
         frameRest      <= '0;
         bytesLeft      <= '0;
         isPoll         <= 1'b0;
         skipBusy       <= 1'b0;
         rxPrev         <= 1'b0;
         rxIdx          <= '0;
         shadow         <= '0;
      end else begin
         cmd_reject     <= 1'b0;
         status_valid   <= 1'b0;
         status_timeout <= 1'b0;
         rxPrev         <= rx_ready;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_motor > 4'd9) begin
                     cmd_reject <= 1'b1;
                  end else begin
                     tx_data   <= {4'h0, cmd_motor};
                     frameRest <= {cmd_dir, cmd_steps, cmd_divider, 4'h0};
                     bytesLeft <= 3'd4;
                     isPoll    <= 1'b0;
                  end
               end else if (poll_req) begin
                  tx_data   <= POLL_BYTE;
                  frameRest <= '0;
                  bytesLeft <= 3'd0;
                  isPoll    <= 1'b1;
               end
            end
            TX_BYTE: begin
               if (!tx_busy) begin
                  skipBusy <= 1'b1;
               end
            end
            TX_WAIT: begin
               skipBusy <= 1'b0;
               if (!skipBusy && !tx_busy) begin
                  cnt <= GAP_LOAD;
               end
            end
            TX_GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else if (bytesLeft != 3'd0) begin
                  tx_data   <= frameRest[7:0];
                  frameRest <= {8'h00, frameRest[31:8]};
                  bytesLeft <= bytesLeft - 3'd1;
               end else if (isPoll) begin
                  cnt   <= TIMEOUT_LOAD;
                  rxIdx <= 2'd0;
               end
            end
            RX_WAIT: begin
               if (replyMatch) begin
                  cnt <= TIMEOUT_LOAD;
                  case (rxIdx)
                     2'd0: shadow[4:0]   <= rx_data[4:0];
                     2'd1: shadow[9:5]   <= rx_data[4:0];
                     2'd2: shadow[14:10] <= rx_data[4:0];
                     default: begin
                        // Last slot goes straight out so all four land on the same edge.
                        pending      <= shadow[9:0];
                        term_active  <= {rx_data[4:0], shadow[14:10]};
                        status_valid <= 1'b1;
                     end
                  endcase
                  rxIdx <= rxIdx + 2'd1;
               end else begin
                  if (resyncByte) begin
                     shadow[4:0] <= rx_data[4:0];
                     rxIdx       <= 2'd1;
                  end else if (rxRise) begin
                     rxIdx <= 2'd0;
                  end
                  if (cnt == '0) begin
                     status_timeout <= 1'b1;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_motor_link_host.sv
// tb_motor_link_host: directed bench with a transmitter model, a byte-queue
// frame model and a reply-window model, checked every cycle at negedge.
module tb_motor_link_host;

   localparam int unsigned G    = 5;
   localparam int unsigned T    = 40;
   localparam int unsigned BUSY = 4;

   logic        CLOCK_25 = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_motor;
   logic [15:0] cmd_divider;
   logic [10:0] cmd_steps;
   logic        cmd_dir;
   logic        cmd_reject;
   logic        poll_req;
   logic        status_valid;
   logic        status_timeout;
   logic [9:0]  pending;
   logic [9:0]  term_active;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [7:0]  rx_data;
   logic        rx_ready;

   always #20 CLOCK_25 = ~CLOCK_25;

   motor_link_host #(.GAP_CYCLES(G), .RESP_TIMEOUT(T)) dut (
      .CLOCK_25(CLOCK_25), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_motor(cmd_motor),
      .cmd_divider(cmd_divider), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir),
      .cmd_reject(cmd_reject), .poll_req(poll_req),
      .status_valid(status_valid), .status_timeout(status_timeout),
      .pending(pending), .term_active(term_active),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .rx_data(rx_data), .rx_ready(rx_ready)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] expQ[$];
   bit         firstQ[$];
   logic [7:0] rep[$];
   logic [9:0] expP = '0;
   logic [9:0] expT = '0;
   logic       expSv = 1'b0;
   logic       expTo = 1'b0;
   logic       expRej = 1'b0;
   logic [7:0] lastTx = '0;
   logic [7:0] popByte;
   bit         popFirst;
   int         cyc = 0;
   int         busyFallCyc = 0;
   int         txCount = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge CLOCK_25) cyc <= cyc + 1;

   // Transmitter model: busy for BUSY cycles after each launch.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge CLOCK_25);
         if (tx_start === 1'b1) begin
            @(posedge CLOCK_25);
            #1 tx_busy = 1'b1;
            repeat (BUSY) @(posedge CLOCK_25);
            #1 tx_busy = 1'b0;
            busyFallCyc = cyc;
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge CLOCK_25) begin
      if (reset_n === 1'b1) begin
         if (tx_start === 1'b1) begin
            txCount++;
            if (expQ.size() == 0) begin
               check("unexpected tx_start", 32'd1, 32'd0);
            end else begin
               popByte  = expQ.pop_front();
               popFirst = firstQ.pop_front();
               check("tx_data", tx_data, popByte);
               // busy drops just after edge P; DUT sees it low at P+1 and launches G+1 cycles later
               if (!popFirst) check("byte spacing", cyc - busyFallCyc, G + 2);
               lastTx = popByte;
            end
         end else if (tx_busy) begin
            check("tx_data hold", tx_data, lastTx);
         end
         check("status_valid", status_valid, expSv);
         check("status_timeout", status_timeout, expTo);
         check("cmd_reject", cmd_reject, expRej);
         check("pending", pending, expP);
         check("term_active", term_active, expT);
      end
   end

   task automatic tick;
      @(posedge CLOCK_25);
      #2;
   endtask

   function automatic logic [7:0] frameByte(input int m, input int d, input int s, input int dir, input int i);
      longint w;
      w = longint'(dir) * 64'd2147483648 + longint'(s) * 64'd1048576 + longint'(d) * 64'd16;
      if (i == 0) return 8'(m);
      return 8'((w >> (8 * (i - 1))) & 64'd255);
   endfunction

   task automatic pushCmd(input int m, input int d, input int s, input int dir);
      for (int i = 0; i < 5; i++) begin
         expQ.push_back(frameByte(m, d, s, dir, i));
         firstQ.push_back(i == 0);
      end
   endtask

   // Reply model: first run of four bytes tagged 0,1,2,3 with bit5 clear.
   function automatic int findWin();
      for (int i = 0; i + 3 < rep.size(); i++) begin
         bit ok = 1'b1;
         for (int k = 0; k < 4; k++) begin
            logic [7:0] b = rep[i + k];
            if (b[7:6] != 2'(k) || b[5]) ok = 1'b0;
         end
         if (ok) return i + 3;
      end
      return -1;
   endfunction

   task automatic sendCmd(input int m, input int d, input int s, input int dir);
      int startTx = txCount;
      bit ok = (m <= 9);
      int n;
      if (ok) pushCmd(m, d, s, dir);
      cmd_motor = 4'(m); cmd_divider = 16'(d); cmd_steps = 11'(s); cmd_dir = 1'(dir);
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      if (!ok) begin
         expRej = 1'b1;
         check("ready after reject", cmd_ready, 1'b1);
         tick;
         expRej = 1'b0;
         repeat (20) tick;
         check("no tx on reject", txCount - startTx, 0);
      end else begin
         check("ready drops", cmd_ready, 1'b0);
         for (n = 0; n < 400 && !(expQ.size() == 0 && !tx_busy && cmd_ready); n++) tick;
         check("frame done in time", n < 400, 1'b1);
         check("tx_start count", txCount - startTx, 5);
         check("ready after frame", cmd_ready, 1'b1);
      end
   endtask

   task automatic runPoll(input bit queued);
      int ci;
      int n;
      if (!queued) begin
         expQ.push_back(8'h0F);
         firstQ.push_back(1'b1);
      end
      poll_req = 1'b1;
      for (n = 0; n < 500 && expQ.size() != 0; n++) tick;
      check("poll launched", expQ.size(), 0);
      poll_req = 1'b0;
      for (n = 0; n < 50 && tx_busy; n++) tick;
      check("poll byte done", tx_busy, 1'b0);
      repeat (G + 4) tick;
      ci = findWin();
      foreach (rep[i]) begin
         rx_data = rep[i];
         rx_ready = 1'b1;
         tick;
         if (i == ci) begin
            expSv = 1'b1;
            expP = {rep[i - 2][4:0], rep[i - 3][4:0]};
            expT = {rep[i][4:0], rep[i - 1][4:0]};
         end
         rx_ready = 1'b0;
         tick;
         expSv = 1'b0;
      end
      if (ci < 0) begin
         repeat (T - 1) tick;
         tick;
         expTo = 1'b1;
         tick;
         expTo = 1'b0;
      end
      check("ready after poll", cmd_ready, 1'b1);
   endtask

   initial begin
      #8000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int txAtReset;
      reset_n = 1'b0; cmd_valid = 1'b0; poll_req = 1'b0; rx_ready = 1'b0; rx_data = '0;
      cmd_motor = '0; cmd_divider = '0; cmd_steps = '0; cmd_dir = 1'b0;

      // Model pinned by hand-computed frame bytes.
      check("model b0", frameByte(3, 'h1234, 'h0A5, 1, 0), 8'h03);
      check("model b1", frameByte(3, 'h1234, 'h0A5, 1, 1), 8'h40);
      check("model b2", frameByte(3, 'h1234, 'h0A5, 1, 2), 8'h23);
      check("model b3", frameByte(3, 'h1234, 'h0A5, 1, 3), 8'h51);
      check("model b4", frameByte(3, 'h1234, 'h0A5, 1, 4), 8'h8A);

      repeat (3) tick;
      check("reset tx_data", tx_data, 8'h00);
      check("reset tx_start", tx_start, 1'b0);
      check("reset pending", pending, 10'h000);
      check("reset term", term_active, 10'h000);
      check("reset sv", status_valid, 1'b0);
      check("reset to", status_timeout, 1'b0);
      check("reset rej", cmd_reject, 1'b0);
      reset_n = 1'b1;
      tick;
      check("ready after reset", cmd_ready, 1'b1);

      sendCmd(3, 'h1234, 'h0A5, 1);

      rep = '{8'h05, 8'h5F, 8'h81, 8'hC0};
      runPoll(1'b0);
      check("poll1 pending", pending, 10'h3E5);
      check("poll1 term", term_active, 10'h001);

      rep = '{8'h05, 8'hC0, 8'h01, 8'h42, 8'h80, 8'hC1};
      runPoll(1'b0);
      check("resync pending", pending, 10'h041);
      check("resync term", term_active, 10'h020);

      rep = '{8'h05, 8'h5F};
      runPoll(1'b0);
      check("timeout keeps pending", pending, 10'h041);
      check("timeout keeps term", term_active, 10'h020);

      sendCmd(10, 'h1234, 'h0A5, 1);
      sendCmd(15, 'h0001, 'h001, 0);
      sendCmd(9, 'hFFFF, 'h7FF, 0);

      // Command and poll together: command frame must go first.
      rep = '{8'h00, 8'h7F, 8'h0A, 8'h5F, 8'h9F, 8'hC7};
      pushCmd(1, 'h0001, 'h001, 0);
      expQ.push_back(8'h0F);
      firstQ.push_back(1'b1);
      cmd_motor = 4'd1; cmd_divider = 16'h0001; cmd_steps = 11'h001; cmd_dir = 1'b0;
      cmd_valid = 1'b1; poll_req = 1'b1;
      tick;
      cmd_valid = 1'b0;
      check("combined ready drops", cmd_ready, 1'b0);
      runPoll(1'b1);
      check("combined pending", pending, 10'h3EA);
      check("combined term", term_active, 10'h0FF);

      // Reset in the middle of byte 2 of a command.
      pushCmd(5, 'h0100, 'h010, 1);
      cmd_motor = 4'd5; cmd_divider = 16'h0100; cmd_steps = 11'h010; cmd_dir = 1'b1;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      for (n = 0; n < 200 && expQ.size() != 3; n++) tick;
      check("reached byte 2", expQ.size(), 3);
      reset_n = 1'b0;
      expQ.delete();
      firstQ.delete();
      lastTx = 8'h00;
      txAtReset = txCount;
      tick;
      expP = '0;
      expT = '0;
      check("mid reset tx_start", tx_start, 1'b0);
      check("mid reset tx_data", tx_data, 8'h00);
      check("mid reset pending", pending, 10'h000);
      check("mid reset term", term_active, 10'h000);
      check("mid reset rej", cmd_reject, 1'b0);
      tick;
      check("mid reset tx_start 2", tx_start, 1'b0);
      reset_n = 1'b1;
      tick;
      check("ready after mid reset", cmd_ready, 1'b1);
      repeat (40) tick;
      check("no tx after reset", txCount - txAtReset, 0);
      check("still idle", cmd_ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/motor_link_host.md
# motor_link_host

Host-side initiator for the motor controller's serial link. Frames 5-byte motion commands and 1-byte status polls onto a byte transmitter, then collects and validates the 4-byte status reply from a byte receiver. Sits between a sequencer (or soft CPU) and the 115200-baud transmitter/receiver pair on a host FPGA that drives the 10-axis motor board.

## Interface

- GAP_CYCLES, 4095: idle cycles inserted after each transmitted byte completes (tx_busy falls).
- RESP_TIMEOUT, 262143: max cycles allowed between poll byte completion and each reply byte.
- CLOCK_25  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; transfer on cmd_valid && cmd_ready.
- cmd_motor  in  4  axis index 0..9.
- cmd_divider  in  16  step period divider.
- cmd_steps  in  11  step count.
- cmd_dir  in  1  direction.
- cmd_reject  out  1  1-cycle pulse: accepted command had cmd_motor > 9, nothing sent.
- poll_req  in  1  level; status poll requested while high in IDLE.
- status_valid  out  1  1-cycle pulse: pending/term_active updated.
- status_timeout  out  1  1-cycle pulse: reply incomplete within RESP_TIMEOUT.
- pending  out  10  per-axis "command loaded, not finished" flags.
- term_active  out  10  per-axis limit-switch active flags.
- tx_data  out  8  byte to send; stable from tx_start until tx_busy falls.
- tx_start  out  1  1-cycle launch pulse.
- tx_busy  in  1  transmitter busy.
- rx_data  in  8  received byte.
- rx_ready  in  1  received-byte strobe; rising edge consumes rx_data.

## Operation

- States: IDLE, TX_BYTE, TX_WAIT, TX_GAP, RX_WAIT.
- IDLE: cmd_valid has priority over poll_req. On command transfer latch fields; motor > 9 -> cmd_reject pulse, remain IDLE. Otherwise load 5-byte frame, go TX_BYTE. On poll_req: load 1-byte frame 0x0F.
- Command frame: byte0 = {4'h0, cmd_motor}; word W = {cmd_dir, cmd_steps, cmd_divider, 4'h0}; bytes 1..4 = W[7:0], W[15:8], W[23:16], W[31:24].
- TX_BYTE: wait tx_busy==0, drive tx_data, pulse tx_start, go TX_WAIT.
- TX_WAIT: ignore tx_busy for the first cycle after tx_start; then wait tx_busy==0, load gap counter with GAP_CYCLES, go TX_GAP.
- TX_GAP: count down to 0; more bytes -> TX_BYTE; command frame done -> IDLE; poll done -> load timeout counter, reply index 0, go RX_WAIT.
- RX_WAIT: on rx_ready rising edge check byte: bits[7:6] == reply index and bit5 == 0. Match: store bits[4:0] in shadow slot (0: pending[4:0], 1: pending[9:5], 2: term_active[4:0], 3: term_active[9:5]), index+1, reload timeout. Mismatch: if tag 0 with bit5 0, store as slot 0, index 1; else index 0. After slot 3: copy shadow to pending/term_active atomically, status_valid pulse, IDLE.
- Timeout counter reaching 0 in RX_WAIT: status_timeout pulse, IDLE, outputs unchanged.
- rx_ready edges outside RX_WAIT ignored; edge detector runs in all states.

## Timing

- Reset (reset_n low at a clock edge): state IDLE; tx_start, cmd_reject, status_valid, status_timeout, tx_data, pending, term_active, counters = 0. cmd_ready = 1 on the first cycle after reset release. Reset mid-frame aborts the frame; no further tx_start.
- cmd_ready combinational from state; falls the cycle after transfer.
- First tx_start no earlier than 1 cycle after transfer.
- Byte spacing: tx_start of byte n+1 occurs exactly GAP_CYCLES+1 cycles after tx_busy falls for byte n (tx_busy already low).
- status_valid asserted 1 cycle after the clock that sees the 4th valid rx_ready rising edge.
- GAP_CYCLES < 262143 is mandatory; the motor board drops partial frames after that idle time.

## Test plan

- Command motor 3, divider 0x1234, steps 0x0A5, dir 1 -> tx bytes 0x03, 0x40, 0x23, 0x51, 0x8A, exactly 5 tx_start pulses, then cmd_ready = 1.
- Poll, model replies 0x05, 0x5F, 0x81, 0xC0 -> tx byte 0x0F; pending = 0x3E5, term_active = 0x001, status_valid single pulse.
- Poll, replies 0x05, 0xC0 (bad tag), 0x01, 0x42, 0x80, 0xC1 -> resync; pending = 0x041, term_active = 0x020.
- Poll with only 2 reply bytes -> status_timeout after RESP_TIMEOUT cycles, pending/term_active keep prior values.
- cmd_motor = 0xA -> cmd_reject pulse, no tx_start; cmd_valid and poll_req together -> command sent first, then poll.
- reset_n low during byte 2 of a command -> tx_start stays 0, all outputs 0, cmd_ready = 1 after release.
